exec_datapath: RTL and testbench

- Execute/memory slice of the 8-bit ExceptioNull CPU.
- Combines three parts behind one valid-qualified, 2-cycle pipeline:
  - instruction decode (control flags and register addresses);
  - 8-bit ALU with signed overflow and branch compare;
  - synchronous byte-wide data memory.
- The register file, instruction memory and PC live outside this block.
- The top level drives instruction, operands and pc, and consumes the write-back data and control-flow flags.

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_datapath_if.sv | 29 ++
 rtl/exec_dmem.sv | 24 ++
 rtl/exec_datapath.sv | 136 +++++++++++++
 tb/tb_exec_datapath.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared opcode map and decoded-control struct for the ExceptioNull execute slice.
package exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_J    = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  typedef struct packed {
    logic       wb_en;
    logic       mem_w_en;
    logic       mem_r_en;
    logic       sel_mem;
    logic       is_branch_eq;
    logic       is_branch_ne;
    logic       is_jump;
    logic [1:0] wb_addr;
  } ctrl_t;

endpackage

// File: rtl/exec_datapath_if.sv
// Instruction-in / write-back-out bundle of the execute slice.
interface exec_datapath_if;
  logic       in_valid;
  logic [7:0] instruction;
  logic [7:0] in0;
  logic [7:0] in1;
  logic [7:0] pc;
  logic [1:0] reg_addr_0;
  logic [1:0] reg_addr_1;
  logic       out_valid;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       overflow;
  logic       branch;
  logic       jump;

  modport master (
    output in_valid, instruction, in0, in1, pc,
    input  reg_addr_0, reg_addr_1, out_valid, wb_en, wb_addr, wb_data,
           overflow, branch, jump
  );

  modport slave (
    input  in_valid, instruction, in0, in1, pc,
    output reg_addr_0, reg_addr_1, out_valid, wb_en, wb_addr, wb_data,
           overflow, branch, jump
  );
endinterface

// File: rtl/exec_dmem.sv
// Byte-wide single-port data RAM with registered read; contents have no reset.
module exec_dmem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/exec_datapath.sv
// Two-stage decode/ALU/data-memory slice of the ExceptioNull CPU.
// Define EXEC_SHIFT_OPS_EN to build the sll/srl shifter; otherwise 0110/0111 are nops.
module exec_datapath
  import exec_pkg::*;
#(
  parameter int DMEM_DEPTH = 256,
  parameter int DMEM_AW    = 8
) (
  input logic            clk,
  input logic            rst,
  exec_datapath_if.slave bus
);

  logic       s1_vld_q;
  logic [7:0] s1_instr_q, s1_a_q, s1_b_q, s1_pc_q;

  logic       out_valid_q, wb_en_q, ovf_q, branch_q, jump_q, sel_mem_q;
  logic [1:0] wb_addr_q;
  logic [7:0] alu_q, mem_rdata;

  ctrl_t      ctrl;
  logic [7:0] alu_d, sum, diff;
  logic       ovf_d;
  logic [3:0] op;
  logic [1:0] fa, fb;

  assign bus.reg_addr_0 = bus.instruction[3:2];
  assign bus.reg_addr_1 = bus.instruction[1:0];

  always_ff @(posedge clk) begin
    if (rst) s1_vld_q <= 1'b0;
    else     s1_vld_q <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_instr_q <= bus.instruction;
      s1_a_q     <= bus.in0;
      s1_b_q     <= bus.in1;
      s1_pc_q    <= bus.pc;
    end
  end

  assign op   = s1_instr_q[7:4];
  assign fa   = s1_instr_q[3:2];
  assign fb   = s1_instr_q[1:0];
  assign sum  = s1_a_q + s1_b_q;
  assign diff = s1_a_q - s1_b_q;

  always_comb begin
    ctrl  = '0;
    alu_d = '0;
    ovf_d = 1'b0;
    case (op)
      OP_ADD: begin
        ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = sum;
        ovf_d = (s1_a_q[7] == s1_b_q[7]) && (sum[7] != s1_a_q[7]);
      end
      OP_SUB: begin
        ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = diff;
        ovf_d = (s1_a_q[7] != s1_b_q[7]) && (diff[7] != s1_a_q[7]);
      end
      OP_AND: begin ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = s1_a_q & s1_b_q; end
      OP_OR:  begin ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = s1_a_q | s1_b_q; end
      OP_XOR: begin ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = s1_a_q ^ s1_b_q; end
      OP_SLT: begin
        ctrl.wb_en = 1'b1; ctrl.wb_addr = fa;
        alu_d = {7'd0, $signed(s1_a_q) < $signed(s1_b_q)};
      end
`ifdef EXEC_SHIFT_OPS_EN
      OP_SLL: begin ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = s1_a_q << s1_b_q[2:0]; end
      OP_SRL: begin ctrl.wb_en = 1'b1; ctrl.wb_addr = fa; alu_d = s1_a_q >> s1_b_q[2:0]; end
`else
      OP_SLL, OP_SRL: ;
`endif
      OP_ADDI: begin
        ctrl.wb_en = 1'b1; ctrl.wb_addr = fa;
        alu_d = s1_a_q + {{6{fb[1]}}, fb};
      end
      OP_NOP: ;
      OP_LW: begin
        ctrl.wb_en = 1'b1; ctrl.mem_r_en = 1'b1; ctrl.sel_mem = 1'b1; ctrl.wb_addr = fb;
      end
      OP_SW:  ctrl.mem_w_en     = 1'b1;
      OP_BEQ: ctrl.is_branch_eq = 1'b1;
      OP_BNE: ctrl.is_branch_ne = 1'b1;
      OP_J:   ctrl.is_jump      = 1'b1;
      OP_JAL: begin
        ctrl.is_jump = 1'b1; ctrl.wb_en = 1'b1; ctrl.wb_addr = 2'd3;
        alu_d = s1_pc_q + 8'd1;
      end
    endcase
  end

  // A store still in stage 2 when reset hits is dropped along with the rest of the pipe.
  exec_dmem #(.DEPTH(DMEM_DEPTH), .AW(DMEM_AW)) u_dmem (
    .clk     (clk),
    .we_i    (s1_vld_q & ctrl.mem_w_en & ~rst),
    .re_i    (s1_vld_q & ctrl.mem_r_en),
    .addr_i  (s1_a_q[DMEM_AW-1:0]),
    .wdata_i (s1_b_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      alu_q       <= '0;
      sel_mem_q   <= 1'b0;
      ovf_q       <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
    end else begin
      out_valid_q <= s1_vld_q;
      wb_en_q     <= s1_vld_q & ctrl.wb_en;
      wb_addr_q   <= ctrl.wb_addr;
      alu_q       <= alu_d;
      sel_mem_q   <= s1_vld_q & ctrl.sel_mem;
      ovf_q       <= s1_vld_q & ovf_d;
      branch_q    <= s1_vld_q & ((ctrl.is_branch_eq & (s1_a_q == s1_b_q)) |
                                 (ctrl.is_branch_ne & (s1_a_q != s1_b_q)));
      jump_q      <= s1_vld_q & ctrl.is_jump;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = sel_mem_q ? mem_rdata : alu_q;
  assign bus.overflow  = ovf_q;
  assign bus.branch    = branch_q;
  assign bus.jump      = jump_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed-vector bench for exec_datapath; expected values are hand-derived constants.
module tb_exec_datapath;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  exec_datapath_if bus ();

  exec_datapath #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ins, a, b, p);
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.in0         = a;
    bus.in1         = b;
    bus.pc          = p;
  endtask

  task automatic idle();
    drive(1'b0, 8'h90, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst_wb_en",     {7'd0, bus.wb_en},     8'h00);
    check("rst_wb_data",   bus.wb_data,           8'h00);
    check("rst_wb_addr",   {6'd0, bus.wb_addr},   8'h00);
    check("rst_flags",     {5'd0, bus.overflow, bus.branch, bus.jump}, 8'h00);
    rst = 1'b0;

    // add with signed overflow; register address outputs are combinational
    drive(1'b1, 8'h01, 8'h7F, 8'h01, 8'h00);
    #1;
    check("reg_addr_0", {6'd0, bus.reg_addr_0}, 8'h00);
    check("reg_addr_1", {6'd0, bus.reg_addr_1}, 8'h01);
    step();
    idle();
    check("lat1_not_valid", {7'd0, bus.out_valid}, 8'h00);
    step();
    check("add_valid", {7'd0, bus.out_valid}, 8'h01);
    check("add_data",  bus.wb_data,           8'h80);
    check("add_ovf",   {7'd0, bus.overflow},  8'h01);
    check("add_wb_en", {7'd0, bus.wb_en},     8'h01);
    check("add_addr",  {6'd0, bus.wb_addr},   8'h00);

    // back-to-back store then load of the same address
    drive(1'b1, 8'hB1, 8'h10, 8'hA5, 8'h00);
    step();
    drive(1'b1, 8'hA2, 8'h10, 8'h00, 8'h00);
    step();
    idle();
    check("sw_valid", {7'd0, bus.out_valid}, 8'h01);
    check("sw_wb_en", {7'd0, bus.wb_en},     8'h00);
    step();
    check("lw_data",  bus.wb_data,           8'hA5);
    check("lw_addr",  {6'd0, bus.wb_addr},   8'h02);
    check("lw_wb_en", {7'd0, bus.wb_en},     8'h01);

    // branches
    drive(1'b1, 8'hC1, 8'h33, 8'h33, 8'h00);
    step();
    drive(1'b1, 8'hD1, 8'h33, 8'h33, 8'h00);
    step();
    idle();
    check("beq_branch", {7'd0, bus.branch}, 8'h01);
    check("beq_wb_en",  {7'd0, bus.wb_en},  8'h00);
    step();
    check("bne_branch", {7'd0, bus.branch}, 8'h00);
    check("bne_valid",  {7'd0, bus.out_valid}, 8'h01);

    // jal
    drive(1'b1, 8'hF0, 8'h00, 8'h00, 8'h2A);
    step();
    idle();
    step();
    check("jal_jump", {7'd0, bus.jump},     8'h01);
    check("jal_addr", {6'd0, bus.wb_addr},  8'h03);
    check("jal_data", bus.wb_data,          8'h2B);
    check("jal_wb_en", {7'd0, bus.wb_en},   8'h01);
    step();
    check("idle_flags", {5'd0, bus.out_valid, bus.wb_en, bus.jump}, 8'h00);

    // reset drops an in-flight store; memory keeps the earlier value
    drive(1'b1, 8'hB1, 8'h20, 8'h11, 8'h00);
    step();
    idle();
    step();
    drive(1'b1, 8'hB1, 8'h20, 8'h55, 8'h00);
    step();
    idle();
    rst = 1'b1;
    step();
    check("rst_flight_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst_flight_wb_en", {7'd0, bus.wb_en},     8'h00);
    rst = 1'b0;
    drive(1'b1, 8'hA2, 8'h20, 8'h00, 8'h00);
    step();
    idle();
    step();
    check("rst_store_dropped", bus.wb_data, 8'h11);

    // sub overflow, slt, addi pipelined
    drive(1'b1, 8'h11, 8'h80, 8'h01, 8'h00);
    step();
    drive(1'b1, 8'h51, 8'hFF, 8'h01, 8'h00);
    step();
    drive(1'b1, 8'h83, 8'h05, 8'h00, 8'h00);
    check("sub_data", bus.wb_data,          8'h7F);
    check("sub_ovf",  {7'd0, bus.overflow}, 8'h01);
    step();
    idle();
    check("slt_data", bus.wb_data,          8'h01);
    check("slt_ovf",  {7'd0, bus.overflow}, 8'h00);
    step();
    check("addi_data", bus.wb_data,         8'h04);
    check("addi_addr", {6'd0, bus.wb_addr}, 8'h00);

    // shift opcode, behaviour depends on build option
    drive(1'b1, 8'h61, 8'h03, 8'h02, 8'h00);
    step();
    idle();
    step();
`ifdef EXEC_SHIFT_OPS_EN
    check("sll_data",  bus.wb_data,       8'h0C);
    check("sll_wb_en", {7'd0, bus.wb_en}, 8'h01);
`else
    check("sll_nop_wb_en", {7'd0, bus.wb_en}, 8'h00);
    check("sll_nop_data",  bus.wb_data,       8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
